// File: rtl/fifo_rx.sv
// Receive FIFO for a link receiver: stores received characters for the host and
// manages flow-control credit by requesting FCTs from the local transmitter.
module fifo_rx #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_run,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              fct_ack,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              f_full,
    output logic              f_empty,
    output logic [AWIDTH:0]   counter,
    output logic [AWIDTH-1:0] credit,
    output logic              fct_req,
    output logic              credit_err,
    output logic              overflow_err
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   FULL_CNT  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   FCT_CHUNK = (AWIDTH + 1)'(8);
    // One more FCT is allowed only while credit stays at or below this level
    localparam logic [AWIDTH:0]   REQ_LIMIT = (AWIDTH + 1)'(DEPTH - 16);
    // Stored plus granted must leave room for a whole FCT worth of characters
    localparam logic [AWIDTH+1:0] OCC_LIMIT = (AWIDTH + 2)'(DEPTH - 8);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } credit_state_t;

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    logic [AWIDTH:0]   counter_r;
    logic [AWIDTH-1:0] credit_r;
    logic [DWIDTH-1:0] data_out_r;
    logic              data_valid_r;
    logic              f_full_r;
    logic              f_empty_r;
    logic              fct_req_r;
    logic              credit_err_r;
    logic              overflow_err_r;
    credit_state_t     state_r;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [AWIDTH:0]   counter_next_s;
    logic [AWIDTH:0]   credit_w_s;
    logic [AWIDTH:0]   credit_tmp_s;
    logic [AWIDTH-1:0] credit_next_s;
    logic [AWIDTH+1:0] occ_s;
    credit_state_t     state_next_s;

    assign wr_acc_s   = wr_en && (counter_r != FULL_CNT);
    assign rd_acc_s   = rd_en && (counter_r != {(AWIDTH + 1){1'b0}});
    assign credit_w_s = {1'b0, credit_r};
    assign occ_s      = {1'b0, counter_r} + {2'b00, credit_r};

    // Occupancy count for the next cycle from the accepted write/read pair
    always_comb begin
        counter_next_s = counter_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   counter_next_s = counter_r + (AWIDTH + 1)'(1);
            2'b01:   counter_next_s = counter_r - (AWIDTH + 1)'(1);
            default: counter_next_s = counter_r;
        endcase
    end

    // Credit FSM next state and next credit value
    always_comb begin
        state_next_s  = state_r;
        credit_tmp_s  = credit_w_s;
        credit_next_s = credit_r;
        if (!link_run) begin
            state_next_s  = ST_IDLE;
            credit_next_s = {AWIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((credit_w_s <= REQ_LIMIT) && (occ_s <= OCC_LIMIT)) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (fct_ack) begin
                        state_next_s = ST_IDLE;
                        credit_tmp_s = credit_w_s + FCT_CHUNK;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
            // Each stored character consumes one unit of credit, never below zero
            if (wr_acc_s && (credit_tmp_s != {(AWIDTH + 1){1'b0}})) begin
                credit_tmp_s = credit_tmp_s - (AWIDTH + 1)'(1);
            end else begin
                credit_tmp_s = credit_tmp_s;
            end
            credit_next_s = credit_tmp_s[AWIDTH-1:0];
        end
    end

    // Character storage; contents are not reset
    always_ff @(posedge clock) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r  <= {AWIDTH{1'b0}};
            rd_ptr_r  <= {AWIDTH{1'b0}};
            counter_r <= {(AWIDTH + 1){1'b0}};
            f_empty_r <= 1'b1;
            f_full_r  <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AWIDTH'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AWIDTH'(1);
            end
            counter_r <= counter_next_s;
            f_empty_r <= (counter_next_s == {(AWIDTH + 1){1'b0}});
            f_full_r  <= (counter_next_s == FULL_CNT);
        end
    end

    // Read data path with one-cycle latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out_r   <= {DWIDTH{1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                data_out_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Credit FSM state, credit register and FCT request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            credit_r  <= {AWIDTH{1'b0}};
            fct_req_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            credit_r  <= credit_next_s;
            fct_req_r <= (state_next_s == ST_REQ);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit_err_r   <= 1'b0;
            overflow_err_r <= 1'b0;
        end else begin
            if (wr_en && (credit_r == {AWIDTH{1'b0}})) begin
                credit_err_r <= 1'b1;
            end
            if (wr_en && (counter_r == FULL_CNT)) begin
                overflow_err_r <= 1'b1;
            end
        end
    end

    assign data_out     = data_out_r;
    assign data_valid   = data_valid_r;
    assign f_full       = f_full_r;
    assign f_empty      = f_empty_r;
    assign counter      = counter_r;
    assign credit       = credit_r;
    assign fct_req      = fct_req_r;
    assign credit_err   = credit_err_r;
    assign overflow_err = overflow_err_r;

endmodule

// File: tb/tb_fifo_rx.sv
// Self-checking bench for fifo_rx: scoreboard of written characters, popped
// and compared whenever the FIFO presents read data.
module tb_fifo_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       link_run;
    logic       wr_en;
    logic [8:0] data_in;
    logic       rd_en;
    logic       fct_ack;
    logic [8:0] data_out;
    logic       data_valid;
    logic       f_full;
    logic       f_empty;
    logic [6:0] counter;
    logic [5:0] credit;
    logic       fct_req;
    logic       credit_err;
    logic       overflow_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         model_cnt = 0;
    int         n_valid = 0;
    logic [8:0] exp_q[$];

    fifo_rx #(.DWIDTH(9), .AWIDTH(6)) dut (
        .clock(clock), .reset(reset), .link_run(link_run), .wr_en(wr_en),
        .data_in(data_in), .rd_en(rd_en), .fct_ack(fct_ack),
        .data_out(data_out), .data_valid(data_valid), .f_full(f_full),
        .f_empty(f_empty), .counter(counter), .credit(credit),
        .fct_req(fct_req), .credit_err(credit_err), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from driven inputs, then compare outputs after the edge
    task automatic tick();
        bit wa;
        bit ra;
        wa = wr_en && (model_cnt < 64);
        ra = rd_en && (model_cnt > 0);
        if (wa) exp_q.push_back(data_in);
        model_cnt = model_cnt + int'(wa) - int'(ra);
        @(posedge clock);
        #1;
        check_eq("data_valid", 32'(data_valid), 32'(ra));
        check_eq("counter", 32'(counter), 32'(model_cnt));
        check_eq("f_empty", 32'(f_empty), 32'(model_cnt == 0));
        check_eq("f_full", 32'(f_full), 32'(model_cnt == 64));
        if (data_valid) begin
            n_valid++;
            check_eq("rd_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        fct_ack = 1'b0;
        data_in = 9'h000;
        exp_q.delete();
        model_cnt = 0;
        @(negedge clock);
        check_eq("rst_counter", 32'(counter), 32'd0);
        check_eq("rst_credit", 32'(credit), 32'd0);
        check_eq("rst_f_empty", 32'(f_empty), 32'd1);
        check_eq("rst_f_full", 32'(f_full), 32'd0);
        check_eq("rst_fct_req", 32'(fct_req), 32'd0);
        check_eq("rst_data_valid", 32'(data_valid), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_errs", 32'({credit_err, overflow_err}), 32'd0);
        check_eq("rst_wr_ptr", 32'(dut.wr_ptr_r), 32'd0);
        reset = 1'b1;
    endtask

    task automatic wait_req(input int max_cycles);
        int k = 0;
        while (!fct_req && k < max_cycles) begin
            tick();
            k++;
        end
        check_eq("fct_req_wait", 32'(fct_req), 32'd1);
    endtask

    task automatic pulse_ack();
        fct_ack = 1'b1;
        tick();
        fct_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] last_c;
        int         v0;
        link_run = 1'b0;
        do_reset();

        // Credit build-up to 56
        link_run = 1'b1;
        wait_req(2);
        for (int i = 0; i < 7; i++) begin
            wait_req(3);
            pulse_ack();
            check_eq("credit_ack", 32'(credit), 32'(8 * (i + 1)));
        end
        check_eq("fct_req_56", 32'(fct_req), 32'd0);
        tick();
        check_eq("fct_req_56_hold", 32'(fct_req), 32'd0);

        // Eight characters with credit
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            data_in = 9'(i);
            tick();
        end
        wr_en = 1'b0;
        check_eq("credit_48", 32'(credit), 32'd48);
        check_eq("fct_req_after8", 32'(fct_req), 32'd0);

        // Fill to 64, acknowledging any FCT request on the way
        for (int i = 8; i < 64; i++) begin
            wr_en = 1'b1;
            data_in = 9'($urandom);
            fct_ack = fct_req;
            tick();
        end
        wr_en = 1'b0;
        fct_ack = 1'b0;
        check_eq("credit_full", 32'(credit), 32'd0);
        check_eq("credit_err_fill", 32'(credit_err), 32'd0);
        check_eq("overflow_before", 32'(overflow_err), 32'd0);
        wr_en = 1'b1;
        data_in = 9'h1AB;
        tick();
        wr_en = 1'b0;
        check_eq("overflow_err", 32'(overflow_err), 32'd1);
        check_eq("wr_ptr_wrap", 32'(dut.wr_ptr_r), 32'd0);

        // Drain everything in write order
        rd_en = 1'b1;
        for (int i = 0; i < 65; i++) tick();
        rd_en = 1'b0;
        check_eq("drained", 32'(exp_q.size()), 32'd0);
        check_eq("overflow_sticky", 32'(overflow_err), 32'd1);

        // Pending request aborted by reset
        wait_req(3);
        link_run = 1'b0;
        do_reset();

        // Link down: ack ignored, credit error, reads past empty
        pulse_ack();
        check_eq("ack_idle_credit", 32'(credit), 32'd0);
        check_eq("ack_idle_req", 32'(fct_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            data_in = 9'h150 + 9'(i);
            last_c = data_in;
            tick();
        end
        wr_en = 1'b0;
        check_eq("credit_err", 32'(credit_err), 32'd1);
        v0 = n_valid;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_en = 1'b0;
        check_eq("valid_pulses", 32'(n_valid - v0), 32'd3);
        check_eq("data_out_hold", 32'(data_out), 32'(last_c));
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            data_in = 9'($urandom);
            tick();
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 9'h0EE;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_eq("wr_rd_same", 32'(counter), 32'd5);
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rd_en = 1'b0;
        check_eq("credit_err_sticky", 32'(credit_err), 32'd1);

        // Link drop with credit 20, counter 10
        link_run = 1'b1;
        do_reset();
        wait_req(2);
        for (int i = 0; i < 4; i++) begin
            wait_req(3);
            pulse_ack();
        end
        check_eq("credit_32", 32'(credit), 32'd32);
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1;
            data_in = 9'h100 | 9'(i * 7);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        check_eq("credit_20", 32'(credit), 32'd20);
        check_eq("fct_req_before_drop", 32'(fct_req), 32'd1);
        link_run = 1'b0;
        tick();
        check_eq("drop_credit", 32'(credit), 32'd0);
        check_eq("drop_fct_req", 32'(fct_req), 32'd0);
        check_eq("drop_counter", 32'(counter), 32'd10);
        rd_en = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd_en = 1'b0;
        check_eq("drop_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rx.md
FIFO_RX -- requirements
Module: fifo_rx

Interface
REQ-001 SHALL have parameter DWIDTH, default 9, character width (bit 8 = control flag, bits 7:0 = data/EOP code).
REQ-002 SHALL have parameter AWIDTH, default 6, address width; depth = 2**AWIDTH (64).
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port link_run  input  1  link in Run state; low = link reset.
REQ-006 SHALL have port wr_en  input  1  one-cycle strobe from the receiver, one character per strobe.
REQ-007 SHALL have port data_in  input  DWIDTH  received character, valid with wr_en.
REQ-008 SHALL have port rd_en  input  1  host read request.
REQ-009 SHALL have port fct_ack  input  1  one-cycle pulse, transmitter has sent one FCT.
REQ-010 SHALL have port data_out  output  DWIDTH  read character, registered.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse qualifying data_out.
REQ-012 SHALL have port f_full / f_empty  output  1 each  occupancy flags.
REQ-013 SHALL have port counter  output  AWIDTH+1  stored character count, 0..64.
REQ-014 SHALL have port credit  output  AWIDTH  outstanding credit granted to the peer, 0..56.
REQ-015 SHALL have port fct_req  output  1  request the transmitter to send one FCT.
REQ-016 SHALL have port credit_err / overflow_err  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be an internal 2**AWIDTH x DWIDTH array with wr_ptr and rd_ptr of AWIDTH bits, each wrapping 63->0.
REQ-018 Write accepted when wr_en=1 and counter<64: store data_in at wr_ptr, wr_ptr+1, credit-1 (saturating at 0).
REQ-019 wr_en=1 with counter=64: character discarded; pointers and counter unchanged; overflow_err set.
REQ-020 wr_en=1 with credit=0: credit_err set; character still stored if not full (REQ-018).
REQ-021 Read accepted when rd_en=1 and counter>0: data_out <= mem[rd_ptr], rd_ptr+1, data_valid=1 on the next cycle (latency 1).
REQ-022 rd_en=1 with counter=0: ignored; data_valid=0; data_out holds its last value.
REQ-023 Write and read accepted in the same cycle: counter unchanged; both pointers advance; reading the slot being written is impossible, since counter>0 is required.
REQ-024 f_empty SHALL equal (counter==0) and f_full SHALL equal (counter==64), both registered and coherent with counter every cycle.
REQ-025 Credit FSM states: IDLE and REQ; fct_req=1 only in REQ.
REQ-026 IDLE->REQ when link_run=1, credit<=48, and (64-counter-credit)>=8.
REQ-027 REQ->IDLE on fct_ack: credit+8; with a simultaneous accepted write, net credit+7.
REQ-028 fct_ack received in IDLE SHALL be ignored.
REQ-029 link_run=0 in any state: FSM->IDLE, credit<=0, fct_req=0 next cycle; FIFO contents, pointers and counter retained; writes are still accepted.
REQ-030 credit_err and overflow_err SHALL clear only on reset.

Reset
REQ-031 reset low asynchronously clears wr_ptr, rd_ptr, counter, credit, data_out, data_valid, fct_req, credit_err and overflow_err; sets f_empty=1 and f_full=0; puts the FSM in IDLE; array contents are don't-care.
REQ-032 reset asserted mid-operation aborts any pending FCT request; after release, behaviour is identical to first power-up.

Verification
REQ-033 Reset, link_run=1 -> fct_req=1 within 2 cycles; pulse fct_ack 7 times -> credit=56, fct_req=0 (credit>48).
REQ-034 Credit 56, write 8 characters 0x001..0x008 -> counter=8, credit=48, f_empty=0, fct_req stays 0 (64-8-48=8 qualifies, so fct_req=1 is also legal here; check only the REQ-026 equation).
REQ-035 Fill to 64 with credit, then one more wr_en -> f_full=1, overflow_err=1, counter=64, wr_ptr=0 (wrapped).
REQ-036 With 3 stored characters, rd_en held 4 cycles -> 3 data_valid pulses with data in write order, then f_empty=1, counter=0.
REQ-037 wr_en with credit=0 -> credit_err=1, character readable afterwards; simultaneous wr_en+rd_en at counter=5 -> counter stays 5.
REQ-038 link_run drops with credit=20 and counter=10 -> credit=0 and fct_req=0 next cycle, counter=10, data preserved.
